// File: rtl/bcd_serial_subtractor_pkg.sv
// Shared constants and state encoding for the serial BCD subtractor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_serial_subtractor_pkg;

  localparam int DIGITS = 4;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SUB   = 3'd2,
    FIX   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of a - b - bin, returning a 0..9 digit and a borrow out.
// Latency: purely combinational.
// Backpressure: none.
module bcd_digit_sub
  import bcd_serial_subtractor_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  logic [DIGIT_W:0] diff;

  // Range is -10..9, so the extra top bit is the sign; negative wraps by +10.
  always_comb begin
    diff = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
    bout = diff[DIGIT_W];
    d    = bout ? (diff[DIGIT_W-1:0] + DIGIT_W'(10)) : diff[DIGIT_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_subtractor.sv
// Serial |in1-in2| over packed BCD operands, one digit per clock, with sign and digit-validity flags.
// Latency: done visible on edge 2 (bad digit), 6 (non-negative) or 10 (negative), counting the start edge as 1.
// Backpressure: none; start is only sampled in IDLE, so requests while busy or in DONE are dropped.
module bcd_serial_subtractor #(
  parameter int DIGITS = bcd_serial_subtractor_pkg::DIGITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] in1,
  input  logic [4*DIGITS-1:0] in2,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] out,
  output logic                bo,
  output logic                n_err
);

  import bcd_serial_subtractor_pkg::state_t;
  import bcd_serial_subtractor_pkg::DIGIT_W;
  import bcd_serial_subtractor_pkg::BCD_MAX;
  import bcd_serial_subtractor_pkg::IDLE;
  import bcd_serial_subtractor_pkg::CHECK;
  import bcd_serial_subtractor_pkg::SUB;
  import bcd_serial_subtractor_pkg::FIX;
  import bcd_serial_subtractor_pkg::DONE;

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int W     = DIGIT_W * DIGITS;

  state_t             state;
  state_t             state_nx;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       res;
  logic [W-1:0]       res_nx;
  logic [IDX_W-1:0]   idx;
  logic               borrow;
  logic               bad_digit;
  logic               last;
  logic [DIGIT_W-1:0] dig_a;
  logic [DIGIT_W-1:0] dig_b;
  logic [DIGIT_W-1:0] dig_d;
  logic               dig_bout;

  // Flag any latched digit outside 0..9 in either operand.
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a_reg[i*DIGIT_W +: DIGIT_W] > BCD_MAX || b_reg[i*DIGIT_W +: DIGIT_W] > BCD_MAX) begin
        bad_digit = 1'b1;
      end
    end
  end

  assign last = (idx == IDX_W'(DIGITS - 1));

  // Digit select: SUB works on a-b, FIX negates the stored ten's-complement result (0-R).
  always_comb begin
    dig_a = '0;
    dig_b = res[idx*DIGIT_W +: DIGIT_W];
    if (state != FIX) begin
      dig_a = a_reg[idx*DIGIT_W +: DIGIT_W];
      dig_b = b_reg[idx*DIGIT_W +: DIGIT_W];
    end
  end

  // Result with the current digit replaced, so DONE can publish it on the same edge.
  always_comb begin
    res_nx = res;
    res_nx[idx*DIGIT_W +: DIGIT_W] = dig_d;
  end

  bcd_digit_sub u_digit (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (borrow),
    .d    (dig_d),
    .bout (dig_bout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and status decode.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nx = CHECK;
      end
      CHECK: begin
        busy     = 1'b1;
        state_nx = bad_digit ? DONE : SUB;
      end
      SUB: begin
        busy = 1'b1;
        if (last) state_nx = dig_bout ? FIX : DONE;
      end
      FIX: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Operand capture, digit walk and result publication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg  <= '0;
      b_reg  <= '0;
      res    <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      out    <= '0;
      bo     <= 1'b0;
      n_err  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= in1;
            b_reg <= in2;
          end
        end
        CHECK: begin
          idx    <= '0;
          borrow <= 1'b0;
          if (bad_digit) begin
            out   <= '0;
            bo    <= 1'b0;
            n_err <= 1'b0;
          end
        end
        SUB: begin
          res    <= res_nx;
          idx    <= idx + 1'b1;
          borrow <= dig_bout;
          if (last) begin
            if (!dig_bout) begin
              out   <= res_nx;
              bo    <= 1'b0;
              n_err <= 1'b1;
            end else begin
              idx    <= '0;
              borrow <= 1'b0;
            end
          end
        end
        FIX: begin
          res    <= res_nx;
          idx    <= idx + 1'b1;
          borrow <= dig_bout;
          if (last) begin
            out   <= res_nx;
            bo    <= 1'b1;
            n_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for the serial BCD subtractor.
// Latency: n/a.
// Backpressure: n/a.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        busy;
  logic        done;
  logic [15:0] out;
  logic        bo;
  logic        n_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] out;
    logic        bo;
    logic        n_err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .bo    (bo),
    .n_err (n_err)
  );

  always #5 clk = ~clk;

  function automatic bit valid_bcd(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (v[i*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [15:0] v);
    int r = 0;
    for (int i = 3; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [15:0] int2bcd(input int n);
    logic [15:0] r = '0;
    int m = n;
    for (int i = 0; i < 4; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int x, y;
    if (!valid_bcd(a) || !valid_bcd(b)) begin
      e.out = '0; e.bo = 1'b0; e.n_err = 1'b0; e.lat = 2;
    end else begin
      x = bcd2int(a);
      y = bcd2int(b);
      if (x >= y) begin
        e.out = int2bcd(x - y); e.bo = 1'b0; e.lat = 6;
      end else begin
        e.out = int2bcd(y - x); e.bo = 1'b1; e.lat = 10;
      end
      e.n_err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [15:0] rand_bcd();
    return int2bcd(int'($urandom_range(0, 9999)));
  endfunction

  // Drive a start request at a falling edge and record what it must produce.
  task automatic issue(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    in1   = a;
    in2   = b;
    start = 1'b1;
    sb.push_back(model(a, b));
  endtask

  // Count edges from the start edge (edge 1) until done is seen; operands are scrambled after edge 1.
  task automatic wait_done(input bit hold, input bit repulse, output int lat, output bit seen);
    lat  = 0;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        if (!hold) start = 1'b0;
        in1 = 16'($urandom);
        in2 = 16'($urandom);
      end
      if (repulse && lat == 3) begin
        start = 1'b1;
        in1   = 16'h0000;
        in2   = 16'h0000;
      end
      if (repulse && lat == 4) start = 1'b0;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    in1   = '0;
    in2   = '0;
    #12;
    checks++;
    if ({busy, done, out, bo, n_err} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: busy/done/out/bo/n_err got %b/%b/%h/%b/%b want 0/0/0000/0/1", busy, done, out, bo, n_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors(input string name, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int   lat;
    bit   seen;
    issue(a, b);
    wait_done(1'b0, 1'b0, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== e.lat) begin
      errors++;
      $display("FAIL %s_latency: %h-%h got %0d (seen=%0d) want %0d", name, a, b, lat, seen, e.lat);
    end
    checks++;
    if ({out, bo, n_err} !== {e.out, e.bo, e.n_err}) begin
      errors++;
      $display("FAIL %s_result: %h-%h got out=%h bo=%b n_err=%b want out=%h bo=%b n_err=%b",
               name, a, b, out, bo, n_err, e.out, e.bo, e.n_err);
    end
  endtask

  task automatic test_hold();
    logic [15:0] o;
    logic        b;
    o = out;
    b = bo;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b busy=%b one cycle after done, want 0/0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (out !== 16'h3087 || {out, bo} !== {o, b}) begin
      errors++;
      $display("FAIL result_hold: out=%h bo=%b want out=3087 bo=0", out, bo);
    end
  endtask

  task automatic test_start_while_busy();
    exp_t e;
    int   lat;
    bit   seen;
    issue(16'h4321, 16'h1234);
    wait_done(1'b0, 1'b1, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== e.lat || {out, bo, n_err} !== {e.out, e.bo, e.n_err}) begin
      errors++;
      $display("FAIL busy_restart: lat=%0d out=%h bo=%b n_err=%b want lat=%0d out=%h bo=%b n_err=%b",
               lat, out, bo, n_err, e.lat, e.out, e.bo, e.n_err);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
        errors++;
        $display("FAIL busy_restart_idle: busy=%b after ignored start, want 0", busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    bit   seen;
    issue(16'h5000, 16'h0001);
    wait_done(1'b1, 1'b0, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== e.lat || {out, bo, n_err} !== {e.out, e.bo, e.n_err}) begin
      errors++;
      $display("FAIL b2b_first: lat=%0d out=%h bo=%b want lat=%0d out=%h bo=%b", lat, out, bo, e.lat, e.out, e.bo);
    end
    in1 = 16'h0000;
    in2 = 16'h0001;
    sb.push_back(model(16'h0000, 16'h0001));
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b done=%b after DONE with start held, want 0/0", busy, done);
    end
    wait_done(1'b0, 1'b0, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || lat !== e.lat || {out, bo, n_err} !== {e.out, e.bo, e.n_err}) begin
      errors++;
      $display("FAIL b2b_second: lat=%0d out=%h bo=%b want lat=%0d out=%h bo=%b", lat, out, bo, e.lat, e.out, e.bo);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    issue(16'h5000, 16'h0001);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    checks++;
    if ({busy, done, out, bo, n_err} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid_sub: busy/done/out/bo/n_err got %b/%b/%h/%b/%b want 0/0/0000/0/1", busy, done, out, bo, n_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_vectors("after_reset", 16'h5000, 16'h0001);
    e = model(16'h5000, 16'h0001);
    checks++;
    if (out !== 16'h4999 || e.out !== out) begin
      errors++;
      $display("FAIL after_reset_value: out=%h want 4999", out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) test_vectors("random", rand_bcd(), rand_bcd());
  endtask

  initial begin
    test_reset();
    test_vectors("positive", 16'h4321, 16'h1234);
    test_hold();
    test_vectors("negative", 16'h1234, 16'h4321);
    test_vectors("zero_minus_one", 16'h0000, 16'h0001);
    test_vectors("equal_max", 16'h9999, 16'h9999);
    test_vectors("max_minus_zero", 16'h9999, 16'h0000);
    test_vectors("invalid_b", 16'h1234, 16'h12A4);
    test_vectors("invalid_a", 16'hF000, 16'h0000);
    test_vectors("valid_after_err", 16'h0010, 16'h0009);
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
